// File: rtl/stream_xbar_wrr_sched.sv
// Weighted round-robin priority scheduler that sits beside a stream crossbar with external priority.
// Define STREAM_XBAR_WRR_SCHED_ASSERT_EN to bind in the simulation-only protocol checker.
module stream_xbar_wrr_sched #(
  parameter int unsigned NumInp      = 32'd0,
  parameter int unsigned NumOut      = 32'd0,
  parameter int unsigned WeightWidth = 32'd4,
  parameter int unsigned IdxWidth    = (NumInp > 32'd1) ? $clog2(NumInp) : 32'd1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NumInp-1:0][WeightWidth-1:0]     weight_i,
  input  logic [NumOut-1:0]                      out_valid_i,
  input  logic [NumOut-1:0]                      out_ready_i,
  input  logic [NumOut-1:0][IdxWidth-1:0]        out_idx_i,
  output logic [NumOut-1:0][IdxWidth-1:0]        rr_o
);

  localparam logic [IdxWidth:0]   NumInpExt = (IdxWidth + 1)'(NumInp);
  localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumInp - 32'd1);

  for (genvar j = 0; j < NumOut; j++) begin : gen_out
    logic [IdxWidth-1:0]    ptr_r;
    logic [IdxWidth-1:0]    ptr_nxt_s;
    logic [IdxWidth-1:0]    idx_s;
    logic [WeightWidth-1:0] cnt_r;
    logic [WeightWidth-1:0] cnt_nxt_s;
    logic [WeightWidth-1:0] wsel_s;
    logic [WeightWidth-1:0] base_s;
    logic [WeightWidth:0]   quota_s;
    logic [WeightWidth:0]   nxt_s;
    logic                   hs_s;

    assign idx_s = out_idx_i[j];
    // Beats naming a nonexistent input are dropped so the pointer never leaves the valid range.
    assign hs_s  = out_valid_i[j] && out_ready_i[j] && ({1'b0, idx_s} < NumInpExt);

    // Select the quota of the input that won this output.
    always_comb begin
      wsel_s = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
        wsel_s = (idx_s == IdxWidth'(i)) ? weight_i[i] : wsel_s;
      end
    end

    assign quota_s = (wsel_s == '0) ? (WeightWidth + 1)'(1) : {1'b0, wsel_s};
    // A grant from a non-pointer input re-anchors the pointer and restarts the count.
    assign base_s  = (idx_s == ptr_r) ? cnt_r : '0;
    assign nxt_s   = {1'b0, base_s} + (WeightWidth + 1)'(1);

    // Next pointer/credit: rotate past the winner once its quota is used up.
    always_comb begin
      ptr_nxt_s = ptr_r;
      cnt_nxt_s = cnt_r;
      if (hs_s) begin
        if (nxt_s >= quota_s) begin
          ptr_nxt_s = (idx_s == LastIdx) ? '0 : idx_s + IdxWidth'(1);
          cnt_nxt_s = '0;
        end else begin
          ptr_nxt_s = idx_s;
          cnt_nxt_s = nxt_s[WeightWidth-1:0];
        end
      end else begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
      end
    end

    // Per-output state; flush wins over a simultaneous handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ptr_r <= '0;
        cnt_r <= '0;
      end else if (flush_i) begin
        ptr_r <= '0;
        cnt_r <= '0;
      end else begin
        ptr_r <= ptr_nxt_s;
        cnt_r <= cnt_nxt_s;
      end
    end

    assign rr_o[j] = ptr_r;
  end

`ifdef STREAM_XBAR_WRR_SCHED_ASSERT_EN
  stream_xbar_wrr_sched_chk #(
    .NumInp   (NumInp),
    .NumOut   (NumOut),
    .IdxWidth (IdxWidth)
  ) i_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .out_valid_i (out_valid_i),
    .out_ready_i (out_ready_i),
    .out_idx_i   (out_idx_i)
  );
`endif

endmodule

`ifdef STREAM_XBAR_WRR_SCHED_ASSERT_EN
// Simulation-only protocol checker for the crossbar side of the scheduler.
module stream_xbar_wrr_sched_chk #(
  parameter int unsigned NumInp   = 32'd1,
  parameter int unsigned NumOut   = 32'd1,
  parameter int unsigned IdxWidth = 32'd1
) (
  input logic                            clk_i,
  input logic                            rst_ni,
  input logic [NumOut-1:0]               out_valid_i,
  input logic [NumOut-1:0]               out_ready_i,
  input logic [NumOut-1:0][IdxWidth-1:0] out_idx_i
);

  if (NumInp == 32'd0) begin : gen_bad_inp
    $error("stream_xbar_wrr_sched: NumInp must be > 0");
  end
  if (NumOut == 32'd0) begin : gen_bad_out
    $error("stream_xbar_wrr_sched: NumOut must be > 0");
  end

  logic [NumOut-1:0]               stall_r;
  logic [NumOut-1:0][IdxWidth-1:0] idx_r;

  // Remember stalled beats so the following cycle can be checked for stability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r <= '0;
      idx_r   <= '0;
    end else begin
      stall_r <= out_valid_i & ~out_ready_i;
      idx_r   <= out_idx_i;
    end
  end

  // Flag out-of-range sources and stalled beats that change or drop.
  always_ff @(posedge clk_i) begin
    for (int unsigned j = 0; j < NumOut; j++) begin
      if (rst_ni && out_valid_i[j] && ({1'b0, out_idx_i[j]} >= (IdxWidth + 1)'(NumInp))) begin
        $error("stream_xbar_wrr_sched: out_idx_i[%0d]=%0d out of range", j, out_idx_i[j]);
      end
      if (rst_ni && stall_r[j] && (!out_valid_i[j] || (out_idx_i[j] != idx_r[j]))) begin
        $error("stream_xbar_wrr_sched: stalled beat on output %0d not held", j);
      end
    end
  end

endmodule
`endif

// File: tb/tb_stream_xbar_wrr_sched.sv
// Directed self-checking bench for stream_xbar_wrr_sched (4x2 instance plus a 3x1 instance).
module tb_stream_xbar_wrr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni;
  logic            flush;
  logic [3:0][3:0] weight;
  logic [1:0]      ovalid;
  logic [1:0]      oready;
  logic [1:0][1:0] oidx;
  logic [1:0][1:0] rr;

  logic [2:0][3:0] w3;
  logic            v3;
  logic            r3;
  logic [0:0][1:0] idx3;
  logic [0:0][1:0] rr3;

  int checks   = 0;
  int failures = 0;

  stream_xbar_wrr_sched #(.NumInp(4), .NumOut(2), .WeightWidth(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .weight_i(weight),
    .out_valid_i(ovalid), .out_ready_i(oready), .out_idx_i(oidx), .rr_o(rr)
  );

  stream_xbar_wrr_sched #(.NumInp(3), .NumOut(1), .WeightWidth(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .weight_i(w3),
    .out_valid_i(v3), .out_ready_i(r3), .out_idx_i(idx3), .rr_o(rr3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic beat0(input logic [1:0] k);
    ovalid = 2'b01; oready = 2'b01; oidx[0] = k;
    step();
    ovalid = 2'b00; oready = 2'b00;
  endtask

  task automatic set_weights(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
    weight[0] = a; weight[1] = b; weight[2] = c; weight[3] = d;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    checks++;
    if (rr !== 4'h0) begin
      failures++; $display("FAIL reset_rr got=%h exp=0", rr);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (rr !== 4'h0 || rr3 !== 2'd0) begin
        failures++; $display("FAIL idle_rr cycle=%0d got=%h/%0d exp=0", i, rr, rr3);
      end
    end
  endtask

  task automatic test_weighted_rotation();
    logic [1:0] grants [10] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    logic [1:0] exp_rr [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    set_weights(4'd3, 4'd1, 4'd2, 4'd1);
    do_flush();
    for (int i = 0; i < 10; i++) begin
      beat0(grants[i]);
      checks++;
      if (rr[0] !== exp_rr[i] || rr[1] !== 2'd0) begin
        failures++;
        $display("FAIL wrr_seq beat=%0d got=%0d/%0d exp=%0d/0", i, rr[0], rr[1], exp_rr[i]);
      end
    end
  endtask

  task automatic test_reanchor_wrap();
    set_weights(4'd3, 4'd1, 4'd2, 4'd1);
    do_flush();
    beat0(2'd0); beat0(2'd0); beat0(2'd0);
    checks++;
    if (rr[0] !== 2'd1) begin
      failures++; $display("FAIL anchor_setup got=%0d exp=1", rr[0]);
    end
    beat0(2'd3);
    checks++;
    if (rr[0] !== 2'd0) begin
      failures++; $display("FAIL wrap_w1 got=%0d exp=0", rr[0]);
    end
    do_flush();
    weight[3] = 4'd2;
    beat0(2'd0); beat0(2'd0); beat0(2'd0);
    beat0(2'd3);
    checks++;
    if (rr[0] !== 2'd3) begin
      failures++; $display("FAIL reanchor_w2 got=%0d exp=3", rr[0]);
    end
    beat0(2'd3);
    checks++;
    if (rr[0] !== 2'd0) begin
      failures++; $display("FAIL reanchor_cnt1 got=%0d exp=0", rr[0]);
    end
  endtask

  task automatic test_weight_edges();
    set_weights(4'd3, 4'd0, 4'd2, 4'd1);
    do_flush();
    beat0(2'd1);
    checks++;
    if (rr[0] !== 2'd2) begin
      failures++; $display("FAIL weight0 got=%0d exp=2", rr[0]);
    end
    set_weights(4'd15, 4'd1, 4'd2, 4'd1);
    do_flush();
    for (int i = 1; i <= 15; i++) begin
      beat0(2'd0);
      checks++;
      if (rr[0] !== ((i == 15) ? 2'd1 : 2'd0)) begin
        failures++; $display("FAIL weight15 grant=%0d got=%0d exp=%0d", i, rr[0], (i == 15) ? 1 : 0);
      end
    end
    set_weights(4'd4, 4'd1, 4'd2, 4'd1);
    do_flush();
    beat0(2'd0); beat0(2'd0); beat0(2'd0);
    checks++;
    if (rr[0] !== 2'd0) begin
      failures++; $display("FAIL lower_setup got=%0d exp=0", rr[0]);
    end
    weight[0] = 4'd2;
    beat0(2'd0);
    checks++;
    if (rr[0] !== 2'd1) begin
      failures++; $display("FAIL lower_weight got=%0d exp=1", rr[0]);
    end
  endtask

  task automatic test_flush_stall();
    set_weights(4'd3, 4'd1, 4'd2, 4'd1);
    do_flush();
    ovalid = 2'b11; oready = 2'b11; oidx[0] = 2'd2; oidx[1] = 2'd1;
    step();
    checks++;
    if (rr[0] !== 2'd2 || rr[1] !== 2'd2) begin
      failures++; $display("FAIL flush_setup got=%0d/%0d exp=2/2", rr[0], rr[1]);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    ovalid = 2'b00; oready = 2'b00;
    checks++;
    if (rr !== 4'h0) begin
      failures++; $display("FAIL flush_hs got=%h exp=0", rr);
    end
    beat0(2'd2);
    ovalid = 2'b01; oready = 2'b00; oidx[0] = 2'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rr[0] !== 2'd2) begin
        failures++; $display("FAIL stall cycle=%0d got=%0d exp=2", i, rr[0]);
      end
    end
    oready = 2'b01;
    step();
    ovalid = 2'b00; oready = 2'b00;
    checks++;
    if (rr[0] !== 2'd3) begin
      failures++; $display("FAIL stall_release got=%0d exp=3", rr[0]);
    end
  endtask

  task automatic test_two_outputs();
    logic [1:0] i0 [3] = '{2'd2, 2'd2, 2'd0};
    logic [1:0] i1 [3] = '{2'd1, 2'd0, 2'd0};
    logic [1:0] v  [3] = '{2'b11, 2'b11, 2'b10};
    logic [1:0] e0 [3] = '{2'd2, 2'd3, 2'd3};
    logic [1:0] e1 [3] = '{2'd2, 2'd0, 2'd0};
    set_weights(4'd3, 4'd1, 4'd2, 4'd1);
    do_flush();
    for (int i = 0; i < 3; i++) begin
      ovalid = v[i]; oready = 2'b11; oidx[0] = i0[i]; oidx[1] = i1[i];
      step();
      checks++;
      if (rr[0] !== e0[i] || rr[1] !== e1[i]) begin
        failures++; $display("FAIL two_out beat=%0d got=%0d/%0d exp=%0d/%0d", i, rr[0], rr[1], e0[i], e1[i]);
      end
    end
    ovalid = 2'b00; oready = 2'b00;
    beat0(2'd0);
    flush = 1'b0;
    checks++;
    if (rr[1] !== 2'd0) begin
      failures++; $display("FAIL two_out_hold got=%0d exp=0", rr[1]);
    end
    // Out1 has used two of input 0's three credits; a third grant rotates it.
    ovalid = 2'b10; oready = 2'b10; oidx[1] = 2'd0;
    step();
    ovalid = 2'b00; oready = 2'b00;
    checks++;
    if (rr[1] !== 2'd1) begin
      failures++; $display("FAIL two_out_third got=%0d exp=1", rr[1]);
    end
  endtask

  task automatic test_bad_idx();
    w3[0] = 4'd1; w3[1] = 4'd2; w3[2] = 4'd1;
    do_flush();
    v3 = 1'b1; r3 = 1'b1; idx3[0] = 2'd1;
    step();
    checks++;
    if (rr3[0] !== 2'd1) begin
      failures++; $display("FAIL bad_setup got=%0d exp=1", rr3[0]);
    end
    idx3[0] = 2'd3;
    step();
    checks++;
    if (rr3[0] !== 2'd1) begin
      failures++; $display("FAIL bad_idx_ignored got=%0d exp=1", rr3[0]);
    end
    idx3[0] = 2'd1;
    step();
    checks++;
    if (rr3[0] !== 2'd2) begin
      failures++; $display("FAIL bad_idx_cnt got=%0d exp=2", rr3[0]);
    end
    idx3[0] = 2'd2;
    step();
    v3 = 1'b0; r3 = 1'b0;
    checks++;
    if (rr3[0] !== 2'd0) begin
      failures++; $display("FAIL wrap_3 got=%0d exp=0", rr3[0]);
    end
  endtask

  task automatic test_async_reset();
    set_weights(4'd3, 4'd1, 4'd2, 4'd1);
    beat0(2'd2);
    checks++;
    if (rr[0] !== 2'd2) begin
      failures++; $display("FAIL async_setup got=%0d exp=2", rr[0]);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (rr !== 4'h0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", rr);
    end
    step();
    rst_ni = 1'b1;
    beat0(2'd0); beat0(2'd0);
    checks++;
    if (rr[0] !== 2'd0) begin
      failures++; $display("FAIL post_reset got=%0d exp=0", rr[0]);
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush = 1'b0;
    weight = '0; ovalid = '0; oready = '0; oidx = '0;
    w3 = '0; v3 = 1'b0; r3 = 1'b0; idx3 = '0;
    test_reset();
    test_weighted_rotation();
    test_reanchor_wrap();
    test_weight_edges();
    test_flush_stall();
    test_two_outputs();
    test_bad_idx();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
